wb_dma_copy: RTL and testbench
==============================

WB_DMA_COPY -- requirements
Module: wb_dma_copy

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max cycles a bus request waits for ack before abort (valid range 1..65535).
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a copy, honoured only when idle.
REQ-005 SHALL have port src_addr  input  32  byte address of first source word, sampled with start.
REQ-006 SHALL have port dst_addr  input  32  byte address of first destination word, sampled with start.
REQ-007 SHALL have port len_words  input  16  number of 32-bit words to copy, sampled with start.
REQ-008 SHALL have port busy  output  1  high while a copy is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse at end of copy, whether completed or aborted.
REQ-010 SHALL have port err  output  1  sticky flag, set on timeout abort, cleared by accepted start or reset.
REQ-011 SHALL have Wishbone classic initiator ports wb_addr out 32, wb_wdata out 32, wb_sel out 4, wb_we out 1, wb_cyc out 1, wb_stb out 1, wb_rdata in 32, wb_ack in 1.

Function
REQ-012 SHALL implement states IDLE, READ, WRITE; all outputs registered.
REQ-013 SHALL, in IDLE with start=1 and len_words!=0, latch src/dst/len, clear err, enter READ next edge; busy=1 from that edge.
REQ-014 SHALL, on start with len_words=0, stay IDLE, issue no bus cycle, clear err, pulse done on the next cycle.
REQ-015 SHALL ignore start while busy.
REQ-016 SHALL in READ drive wb_cyc=1, wb_stb=1, wb_we=0, wb_sel=4'hF, wb_addr=current source address.
REQ-017 SHALL capture wb_rdata into a word buffer only on an edge where wb_ack=1; wb_rdata is don't-care when wb_ack=0.
REQ-018 SHALL on READ ack enter WRITE the same edge: wb_we=1, wb_addr=current destination, wb_wdata=buffer, wb_sel=4'hF, cyc/stb held high.
REQ-019 SHALL on WRITE ack increment source and destination by 4 (modulo 2^32, address bits [1:0] unchanged) and decrement remaining count.
REQ-020 SHALL after WRITE ack with remaining count now zero drop cyc/stb/we, deassert busy, pulse done, enter IDLE; otherwise enter READ for next word.
REQ-021 SHALL change wb_addr/wb_we only on an edge where wb_ack was sampled high, so a responder with one-cycle registered ack sees exactly one request per phase.
REQ-022 SHALL keep per-word latency at 4 cycles against a responder that acks one cycle after stb (request edge, ack edge, per phase).
REQ-023 SHALL keep a 16-bit wait counter, zeroed on entry to READ/WRITE, incremented each cycle without ack.
REQ-024 SHALL, when wait counter reaches TIMEOUT without ack, drop cyc/stb/we, set err, pulse done, deassert busy, enter IDLE; remaining words untouched.
REQ-025 SHALL drive wb_cyc=wb_stb=0 in IDLE; wb_addr/wb_wdata hold last values.

Reset
REQ-026 SHALL on reset edge enter IDLE; busy=0, done=0, err=0, wb_cyc=0, wb_stb=0, wb_we=0, wb_sel=0, wb_addr=0, wb_wdata=0, counters=0.
REQ-027 SHALL on reset mid-copy abandon the transfer at that edge without done pulse; an in-flight write whose ack arrives later is ignored.

Verification
REQ-028 SHALL cover: mem[0x100..0x10F]=11,22,33,44 (words); start src=0x100 dst=0x200 len=4 with 1-cycle-ack RAM -> mem[0x200..]=11,22,33,44, done exactly 16 cycles after start edge, err=0.
REQ-029 SHALL cover: start len=0 -> no wb_stb ever high, done pulse next cycle, busy never high.
REQ-030 SHALL cover: responder never acks, TIMEOUT=8 -> stb high 8 cycles, then err=1, done pulse, cyc=0; next start clears err.
REQ-031 SHALL cover: src=0xFFFFFFFC len=2 -> second read at wb_addr=0x00000000.
REQ-032 SHALL cover: start asserted again while busy, and reset during WRITE of word 2 -> second start ignored; after reset all outputs at reset values, word 2 destination unchanged.
REQ-033 SHALL cover: responder returns 0x2A with ack low -> buffered/written data equals source word, never 0x2A.

Source files
------------

// File: rtl/wb_dma_copy.sv
// Word-by-word memory copy engine with a Wishbone classic initiator port.
// Each word is read into the write-data register, then written out. A stalled phase aborts after TIMEOUT cycles.
module wb_dma_copy #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] len_words,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] wb_addr,
  output logic [31:0] wb_wdata,
  output logic [3:0]  wb_sel,
  output logic        wb_we,
  output logic        wb_cyc,
  output logic        wb_stb,
  input  logic [31:0] wb_rdata,
  input  logic        wb_ack
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  localparam logic [15:0] WaitLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] src_q, src_d, dst_q, dst_d;
  logic [15:0] rem_q, rem_d, wait_q, wait_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d, cyc_q, cyc_d, stb_q, stb_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
    end
  end

  always_comb begin
    // NOTE: every target gets a default first, so no path through the case can infer a latch.
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    wait_d  = wait_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (len_words != 16'd0) begin
            state_d = READ;
            src_d   = src_addr;
            dst_d   = dst_addr;
            rem_d   = len_words;
            wait_d  = '0;
            busy_d  = 1'b1;
            addr_d  = src_addr;
            sel_d   = 4'hF;
            we_d    = 1'b0;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      READ, WRITE: begin
        if (wb_ack) begin
          wait_d = '0;
          if (state_q == READ) begin
            state_d = WRITE;
            wdata_d = wb_rdata;
            addr_d  = dst_q;
            we_d    = 1'b1;
          end else begin
            src_d = src_q + 32'd4;
            dst_d = dst_q + 32'd4;
            rem_d = rem_q - 16'd1;
            we_d  = 1'b0;
            if (rem_q == 16'd1) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              cyc_d   = 1'b0;
              stb_d   = 1'b0;
            end else begin
              state_d = READ;
              addr_d  = src_q + 32'd4;
            end
          end
        end else if (wait_q == WaitLast) begin
          // Stalled responder: abandon the copy, leaving remaining words untouched.
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          we_d    = 1'b0;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign wb_addr  = addr_q;
  assign wb_wdata = wdata_q;
  assign wb_sel   = sel_q;
  assign wb_we    = we_q;
  assign wb_cyc   = cyc_q;
  assign wb_stb   = stb_q;

endmodule

// File: tb/tb_wb_dma_copy.sv
// Directed bench for wb_dma_copy: registered one-cycle-ack RAM responder that drives 0x2A on rdata whenever ack is low.
module tb_wb_dma_copy;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] len_words;
  logic        busy, done, err;
  logic [31:0] wb_addr, wb_wdata, wb_rdata;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb, wb_ack;

  logic [31:0] mem [0:1023];
  logic [31:0] rdata_q;
  logic        ack_en;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  wb_dma_copy #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
    .busy(busy), .done(done), .err(err),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_sel(wb_sel), .wb_we(wb_we),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_rdata(wb_rdata), .wb_ack(wb_ack)
  );

  // RAM responder sharing the bus reset: acks one cycle after a request, never twice in a row.
  always @(posedge clk) begin
    if (reset) begin
      wb_ack <= 1'b0;
    end else if (ack_en && wb_cyc && wb_stb && !wb_ack) begin
      wb_ack  <= 1'b1;
      rdata_q <= mem[wb_addr[11:2]];
      if (wb_we) mem[wb_addr[11:2]] <= wb_wdata;
    end else begin
      wb_ack <= 1'b0;
    end
  end
  assign wb_rdata = wb_ack ? rdata_q : 32'h0000_002A;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one edge; returns one time unit after that start edge.
  task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    start = 1'b1; src_addr = s; dst_addr = d; len_words = n;
    tick();
    start = 1'b0;
  endtask

  // Cycles from the start edge to the done edge (-1 on budget overrun), stb-high cycles and read addresses.
  task automatic run_until_done(output int cycles, output int stb_cnt,
                                output logic [31:0] rd0, output logic [31:0] rd1);
    int  n_rd = 0;
    logic prev_rd = 1'b0;
    cycles = -1; stb_cnt = 0; rd0 = 'x; rd1 = 'x;
    for (int n = 0; n < 60; n++) begin
      if (wb_stb) stb_cnt++;
      if (wb_stb && !wb_we && !prev_rd) begin
        if (n_rd == 0) rd0 = wb_addr; else if (n_rd == 1) rd1 = wb_addr;
        n_rd++;
      end
      prev_rd = wb_stb && !wb_we;
      if (done) begin
        cycles = n;
        break;
      end
      tick();
    end
  endtask

  int          cyc, stbs;
  logic [31:0] rd0, rd1;
  logic        stb_seen, busy_seen, done_seen;

  initial begin
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len_words = '0; ack_en = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem['h100 >> 2] = 32'h11; mem['h104 >> 2] = 32'h22;
    mem['h108 >> 2] = 32'h33; mem['h10C >> 2] = 32'h44;
    mem[1023] = 32'hA5A5_0001; mem[0] = 32'h5A5A_0002;
    mem['h404 >> 2] = 32'hDEAD_BEEF;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cyc",  wb_cyc, 0);
    check("rst_sel",  wb_sel, 0);
    check("rst_addr", wb_addr, 0);
    tick();

    // Four-word copy against the 1-cycle-ack RAM.
    kick(32'h100, 32'h200, 16'd4);
    check("cp_busy", busy, 1);
    check("cp_addr0", wb_addr, 32'h100);
    check("cp_sel", wb_sel, 4'hF);
    run_until_done(cyc, stbs, rd0, rd1);
    check("cp_latency", cyc, 16);
    check("cp_err", err, 0);
    check("cp_idle_cyc", wb_cyc, 0);
    tick();
    check("cp_done_pulse", done, 0);
    check("cp_busy_end", busy, 0);
    check("cp_w0", mem['h200 >> 2], 32'h11);
    check("cp_w1", mem['h204 >> 2], 32'h22);
    check("cp_w2", mem['h208 >> 2], 32'h33);
    check("cp_w3", mem['h20C >> 2], 32'h44);
    check("cp_wdata_hold", wb_wdata, 32'h44);

    // Zero-length start: done next cycle, no bus activity, never busy.
    stb_seen = 0; busy_seen = 0;
    kick(32'h100, 32'h280, 16'd0);
    check("z_done", done, 1);
    for (int i = 0; i < 4; i++) begin
      stb_seen |= wb_stb; busy_seen |= busy;
      tick();
      if (i == 0) check("z_done_clear", done, 0);
    end
    check("z_stb", stb_seen, 0);
    check("z_busy", busy_seen, 0);
    check("z_mem", mem['h280 >> 2], 0);

    // Silent responder: abort after 8 stb cycles.
    ack_en = 1'b0;
    kick(32'h100, 32'h300, 16'd2);
    run_until_done(cyc, stbs, rd0, rd1);
    check("to_stb_cycles", stbs, 8);
    check("to_latency", cyc, 8);
    check("to_err", err, 1);
    check("to_cyc", wb_cyc, 0);
    check("to_busy", busy, 0);
    check("to_untouched", mem['h300 >> 2], 0);
    ack_en = 1'b1;
    tick();
    check("to_err_sticky", err, 1);
    kick(32'h0, 32'h0, 16'd0);
    check("to_err_clear", err, 0);
    tick();

    // Source address wraps past 0xFFFFFFFC.
    kick(32'hFFFF_FFFC, 32'h300, 16'd2);
    run_until_done(cyc, stbs, rd0, rd1);
    check("wr_rd0", rd0, 32'hFFFF_FFFC);
    check("wr_rd1", rd1, 32'h0);
    check("wr_w0", mem['h300 >> 2], 32'hA5A5_0001);
    check("wr_w1", mem['h304 >> 2], 32'h5A5A_0002);
    tick();

    // Start while busy is ignored; reset during WRITE of word 2 abandons it.
    done_seen = 0;
    kick(32'h100, 32'h400, 16'd4);
    tick(); tick();
    start = 1'b1; src_addr = 32'h180; dst_addr = 32'h500; len_words = 16'd1;
    tick();
    start = 1'b0;
    done_seen |= done;
    tick();
    check("bs_rd1_addr", wb_addr, 32'h104);
    check("bs_rd1_we", wb_we, 0);
    done_seen |= done;
    tick();
    done_seen |= done;
    tick();
    check("bs_wr1_addr", wb_addr, 32'h404);
    check("bs_wr1_we", wb_we, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rs_busy", busy, 0);
    check("rs_done", done, 0);
    check("rs_err", err, 0);
    check("rs_cyc", wb_cyc, 0);
    check("rs_stb", wb_stb, 0);
    check("rs_we", wb_we, 0);
    check("rs_sel", wb_sel, 0);
    check("rs_addr", wb_addr, 0);
    check("rs_wdata", wb_wdata, 0);
    for (int i = 0; i < 4; i++) begin
      done_seen |= done;
      tick();
    end
    check("rs_no_done", done_seen, 0);
    check("rs_w0", mem['h400 >> 2], 32'h11);
    check("rs_w1_kept", mem['h404 >> 2], 32'hDEAD_BEEF);
    check("rs_ignored_dst", mem['h500 >> 2], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
